// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Data_Memory arbiter.
// State encodings and master indices are fixed so waveforms stay readable across the CPU.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
    function automatic int wd_width(input int timeout_cyc);
        return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_last_i,
    output logic valid_o,
    output logic winner_o
);

    // Combinational winner selection
    always_comb begin
        valid_o = req0_i | req1_i;
        if (req0_i && req1_i) begin
            winner_o = ~rr_last_i;
        end else begin
            winner_o = req1_i;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Serialises icache (m0) and dcache (m1) enable/ack transactions onto the single
// Data_Memory port, round-robin, with a BUSY watchdog and a sticky timeout flag.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 256,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              timeout_o
);

    localparam int              WD_W    = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYC);

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              rr_last_q, rr_last_d;
    logic              req_write_q, req_write_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_data_q, req_data_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              timeout_q, timeout_d;

    logic              pick_valid_s, pick_winner_s;
    logic              busy_s, wd_expire_s, finish_s;
    logic [DATA_W-1:0] rdata_s;

    rr_pick2 u_pick (
        .req0_i    (m0_enable_i),
        .req1_i    (m1_enable_i),
        .rr_last_i (rr_last_q),
        .valid_o   (pick_valid_s),
        .winner_o  (pick_winner_s)
    );

    assign busy_s      = (state_q == ST_BUSY);
    assign wd_expire_s = (TIMEOUT_CYC != 0) && busy_s && (wd_cnt_q == WD_LAST);

    // Next-state, request latching and watchdog
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_last_d   = rr_last_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_d     = ST_BUSY;
                    gnt_d       = pick_winner_s;
                    rr_last_d   = pick_winner_s;
                    req_write_d = (pick_winner_s == M1) ? m1_write_i : m0_write_i;
                    req_addr_d  = (pick_winner_s == M1) ? m1_addr_i  : m0_addr_i;
                    req_data_d  = (pick_winner_s == M1) ? m1_data_i  : m0_data_i;
                    wd_cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // A real ack beats a same-cycle watchdog expiry.
                if (mem_ack_i) begin
                    state_d = ST_RELEASE;
                end else if (wd_expire_s) begin
                    state_d   = ST_RELEASE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = (wd_cnt_q == WD_SAT) ? wd_cnt_q : wd_cnt_q + WD_W'(1);
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            gnt_q       <= M0;
            rr_last_q   <= M1;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_last_q   <= rr_last_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Ack path is combinational from mem_ack_i; an abort returns zero data.
    assign finish_s = busy_s && (mem_ack_i || wd_expire_s);
    assign rdata_s  = (busy_s && mem_ack_i) ? mem_data_i : '0;

    assign m0_ack_o  = finish_s && (gnt_q == M0);
    assign m1_ack_o  = finish_s && (gnt_q == M1);
    assign m0_data_o = m0_ack_o ? rdata_s : '0;
    assign m1_data_o = m1_ack_o ? rdata_s : '0;

    assign mem_enable_o = busy_s;
    assign mem_write_o  = busy_s && req_write_q;
    assign mem_addr_o   = busy_s ? req_addr_q : '0;
    assign mem_data_o   = busy_s ? req_data_q : '0;
    assign timeout_o    = timeout_q;

endmodule
